// File: rtl/noise_sched_pkg.sv
// Shared types and the per-requester preset table for the noise voice scheduler.
// Requester index doubles as priority: higher index wins the generator.
package noise_sched_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, TRIG, PLAY} state_e;

    typedef enum logic {SUSTAIN, ONESHOT} mode_e;

    localparam int unsigned NUM_PRESETS  = 4;
    localparam int unsigned PRESET_DUR_W = 24;

    typedef struct packed {
        logic [2:0]              cutoff;
        logic [2:0]              gain;
        logic [3:0]              attack;
        logic [3:0]              decay;
        logic [15:0]             amp;
        mode_e                   mode;
        logic [PRESET_DUR_W-1:0] duration;
    } preset_t;

    localparam preset_t PRESET_THRUST = '{
        cutoff: 3'd3, gain: 3'd2, attack: 4'd4, decay: 4'd15,
        amp: 16'hFFFF, mode: SUSTAIN, duration: 24'd0
    };
    localparam preset_t PRESET_LANDING = '{
        cutoff: 3'd5, gain: 3'd1, attack: 4'd2, decay: 4'd12,
        amp: 16'h8000, mode: ONESHOT, duration: 24'd2_000_000
    };
    localparam preset_t PRESET_ALARM = '{
        cutoff: 3'd1, gain: 3'd3, attack: 4'd1, decay: 4'd11,
        amp: 16'hC000, mode: ONESHOT, duration: 24'd4_000_000
    };
    localparam preset_t PRESET_CRASH = '{
        cutoff: 3'd0, gain: 3'd4, attack: 4'd1, decay: 4'd9,
        amp: 16'hFFFF, mode: ONESHOT, duration: 24'd12_000_000
    };

    localparam preset_t [NUM_PRESETS-1:0] PRESET = {
        PRESET_CRASH, PRESET_ALARM, PRESET_LANDING, PRESET_THRUST
    };

endpackage

// File: rtl/noise_req_latch.sv
// Rising-edge detect and pending latch for one-shot requesters.
// A pending bit is cleared by its ack; a fresh edge in the same cycle re-arms it.
module noise_req_latch #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] oneshot_mask,
    input  logic [NUM_REQ-1:0] ack,
    output logic [NUM_REQ-1:0] pending
);

    logic [NUM_REQ-1:0] req_q, req_d;
    logic [NUM_REQ-1:0] pending_q, pending_d;
    logic [NUM_REQ-1:0] rise;

    always_comb begin
        req_d     = req;
        rise      = req & ~req_q & oneshot_mask;
        pending_d = (pending_q & ~ack) | rise;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            req_q     <= '0;
            pending_q <= '0;
        end else begin
            req_q     <= req_d;
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

endmodule

// File: rtl/noise_voice_scheduler.sv
// Shares one attack/decay noise generator among prioritised sound-event requesters,
// loading presets, pulsing the generator reset to retrigger and timing one-shots.
module noise_voice_scheduler
    import noise_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned TRIG_CYCLES = 4,
    parameter int unsigned DUR_W       = 24,
    parameter int unsigned DUR_SHIFT   = 0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [2:0]         cfg_cutoff,
    output logic [2:0]         cfg_gain,
    output logic [3:0]         cfg_attack,
    output logic [3:0]         cfg_decay,
    output logic [15:0]        cfg_amp,
    output logic               gen_reset,
    output logic               mute,
    output logic               busy,
    output logic [1:0]         active_id,
    output logic [NUM_REQ-1:0] ack
);

    localparam int unsigned TRIG_W = $clog2(TRIG_CYCLES + 1);

    state_e             state_q, state_d;
    logic [1:0]         win_q, win_d;
    logic [1:0]         active_id_q, active_id_d;
    logic [2:0]         cutoff_q, cutoff_d;
    logic [2:0]         gain_q, gain_d;
    logic [3:0]         attack_q, attack_d;
    logic [3:0]         decay_q, decay_d;
    logic [15:0]        amp_q, amp_d;
    logic [DUR_W-1:0]   cnt_q, cnt_d;
    logic [TRIG_W-1:0]  trig_q, trig_d;
    logic               gen_reset_q, gen_reset_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;

    logic [NUM_REQ-1:0] oneshot_mask;
    logic [NUM_REQ-1:0] pending;
    logic [NUM_REQ-1:0] cand;
    logic [1:0]         winner;
    logic               any_cand;
    logic               interrupt;
    logic               play_done;
    logic               take;

    noise_req_latch #(
        .NUM_REQ (NUM_REQ)
    ) u_req_latch (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .oneshot_mask (oneshot_mask),
        .ack          (ack_q),
        .pending      (pending)
    );

    always_comb begin
        oneshot_mask = '0;
        winner       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            oneshot_mask[i] = (PRESET[2'(i)].mode == ONESHOT);
        end
        cand     = pending | (req & ~oneshot_mask);
        any_cand = |cand;
        // Ascending scan: the last set bit is the highest priority.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (cand[i]) winner = 2'(i);
        end
        interrupt = (any_cand && (winner > active_id_q)) || pending[active_id_q];
    end

    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        active_id_d = active_id_q;
        cutoff_d    = cutoff_q;
        gain_d      = gain_q;
        attack_d    = attack_q;
        decay_d     = decay_q;
        amp_d       = amp_q;
        cnt_d       = cnt_q;
        trig_d      = trig_q;
        gen_reset_d = 1'b0;
        ack_d       = '0;
        play_done   = 1'b0;
        take        = 1'b0;

        unique case (state_q)
            IDLE: begin
                take = any_cand;
            end
            LOAD: begin
                state_d     = TRIG;
                active_id_d = win_q;
                cutoff_d    = PRESET[win_q].cutoff;
                gain_d      = PRESET[win_q].gain;
                attack_d    = PRESET[win_q].attack;
                decay_d     = PRESET[win_q].decay;
                amp_d       = PRESET[win_q].amp;
                cnt_d       = DUR_W'(PRESET[win_q].duration >> DUR_SHIFT);
                trig_d      = '0;
                gen_reset_d = 1'b1;
            end
            TRIG: begin
                if (interrupt) begin
                    take = 1'b1;
                end else if (trig_q == TRIG_W'(TRIG_CYCLES - 1)) begin
                    state_d = PLAY;
                end else begin
                    trig_d      = trig_q + TRIG_W'(1);
                    gen_reset_d = 1'b1;
                end
            end
            PLAY: begin
                if (oneshot_mask[active_id_q]) begin
                    // A loaded count of 0 or 1 both give a single PLAY cycle.
                    if (cnt_q <= DUR_W'(1)) begin
                        play_done = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q - DUR_W'(1);
                    end
                end else if (!req[active_id_q]) begin
                    play_done = 1'b1;
                end
                if (interrupt) play_done = 1'b1;
                if (play_done) begin
                    if (any_cand) take = 1'b1;
                    else          state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (take) begin
            state_d = LOAD;
            win_d   = winner;
            ack_d   = NUM_REQ'(1) << winner;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            win_q       <= '0;
            active_id_q <= '0;
            cutoff_q    <= '0;
            gain_q      <= '0;
            attack_q    <= '0;
            decay_q     <= '0;
            amp_q       <= '0;
            cnt_q       <= '0;
            trig_q      <= '0;
            gen_reset_q <= 1'b1;
            ack_q       <= '0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            active_id_q <= active_id_d;
            cutoff_q    <= cutoff_d;
            gain_q      <= gain_d;
            attack_q    <= attack_d;
            decay_q     <= decay_d;
            amp_q       <= amp_d;
            cnt_q       <= cnt_d;
            trig_q      <= trig_d;
            gen_reset_q <= gen_reset_d;
            ack_q       <= ack_d;
        end
    end

    assign cfg_cutoff = cutoff_q;
    assign cfg_gain   = gain_q;
    assign cfg_attack = attack_q;
    assign cfg_decay  = decay_q;
    assign cfg_amp    = amp_q;
    assign gen_reset  = gen_reset_q;
    assign mute       = (state_q != PLAY);
    assign busy       = (state_q != IDLE);
    assign active_id  = active_id_q;
    assign ack        = ack_q;

endmodule

// File: tb/tb_noise_voice_scheduler.sv
// Self-checking bench for noise_voice_scheduler: directed scenarios plus a randomized
// run checked cycle by cycle against an event-level reference model.
module tb_noise_voice_scheduler;

    localparam int TRIG_CYC = 4;
    localparam int SHIFT    = 20;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req   = 4'b0;
    logic [2:0]  cfg_cutoff, cfg_gain;
    logic [3:0]  cfg_attack, cfg_decay;
    logic [15:0] cfg_amp;
    logic        gen_reset, mute, busy;
    logic [1:0]  active_id;
    logic [3:0]  ack;

    int n_cmp = 0;
    int n_err = 0;

    noise_voice_scheduler #(
        .NUM_REQ     (4),
        .TRIG_CYCLES (TRIG_CYC),
        .DUR_W       (24),
        .DUR_SHIFT   (SHIFT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .cfg_cutoff (cfg_cutoff),
        .cfg_gain   (cfg_gain),
        .cfg_attack (cfg_attack),
        .cfg_decay  (cfg_decay),
        .cfg_amp    (cfg_amp),
        .gen_reset  (gen_reset),
        .mute       (mute),
        .busy       (busy),
        .active_id  (active_id),
        .ack        (ack)
    );

    always #5 clock = ~clock;

    // Preset table as listed for the four sound events.
    int       cut_t [4] = '{3, 5, 1, 0};
    int       gain_t[4] = '{2, 1, 3, 4};
    int       att_t [4] = '{4, 2, 1, 1};
    int       dec_t [4] = '{15, 12, 11, 9};
    int       amp_t [4] = '{'hFFFF, 'h8000, 'hC000, 'hFFFF};
    int       dur_t [4] = '{0, 2000000, 4000000, 12000000};
    bit [3:0] ONE       = 4'b1110;

    // Reference model: phase 0 idle, 1 accepting, 2 retriggering, 3 sounding.
    int       m_ph, m_sel, m_own, m_trig_n, m_play_n;
    bit [3:0] m_pend, m_prev;
    bit [2:0] e_cut, e_gain;
    bit [3:0] e_att, e_dec, e_ack;
    bit [15:0] e_amp;
    bit       e_gr;

    task automatic model_step(input logic rst, input logic [3:0] r);
        bit [3:0] cand, npend, nack;
        int  win, nph, need;
        bit  anyc, intr, take, done;
        if (rst) begin
            m_ph = 0; m_sel = 0; m_own = 0; m_trig_n = 0; m_play_n = 0;
            m_pend = 0; m_prev = 0;
            e_cut = 0; e_gain = 0; e_att = 0; e_dec = 0; e_amp = 0;
            e_gr = 1; e_ack = 0;
            return;
        end
        cand = m_pend | (r & ~ONE);
        anyc = (cand != 0);
        win  = 0;
        for (int i = 0; i < 4; i++) if (cand[i]) win = i;
        intr  = (anyc && win > m_own) || m_pend[m_own];
        npend = (m_pend & ~e_ack) | (r & ~m_prev & ONE);
        nph   = m_ph;
        take  = 0;
        done  = 0;
        case (m_ph)
            0: take = anyc;
            1: begin
                nph = 2; m_own = m_sel; m_trig_n = 0; m_play_n = 0;
                e_cut = 3'(cut_t[m_sel]); e_gain = 3'(gain_t[m_sel]);
                e_att = 4'(att_t[m_sel]); e_dec = 4'(dec_t[m_sel]);
                e_amp = 16'(amp_t[m_sel]);
            end
            2: begin
                if (intr) take = 1;
                else begin
                    m_trig_n++;
                    if (m_trig_n == TRIG_CYC) nph = 3;
                end
            end
            default: begin
                m_play_n++;
                need = dur_t[m_own] >> SHIFT;
                if (need == 0) need = 1;
                if (ONE[m_own]) done = (m_play_n >= need);
                else            done = !r[m_own];
                if (done || intr) begin
                    if (anyc) take = 1;
                    else      nph = 0;
                end
            end
        endcase
        nack = 0;
        if (take) begin
            nph = 1; m_sel = win; nack[win] = 1;
        end
        e_gr = (nph == 2); e_ack = nack;
        m_pend = npend; m_prev = r; m_ph = nph;
    endtask

    task automatic tick();
        model_step(reset, req);
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1; req = 0;
        tick(); tick();
        n_cmp++;
        if ({gen_reset, mute, busy, ack} !== {1'b1, 1'b1, 1'b0, 4'b0}) begin
            n_err++;
            $display("FAIL reset_ctl: got gr/mute/busy/ack=%b req %b",
                     {gen_reset, mute, busy, ack}, 7'b1100000);
        end
        n_cmp++;
        if ({cfg_cutoff, cfg_gain, cfg_attack, cfg_decay, cfg_amp, active_id} !== 32'h0) begin
            n_err++;
            $display("FAIL reset_cfg: got %h req 0",
                     {cfg_cutoff, cfg_gain, cfg_attack, cfg_decay, cfg_amp, active_id});
        end
        reset = 0;
        tick();
        n_cmp++;
        if (busy !== 1'b0 || gen_reset !== 1'b0 || mute !== 1'b1) begin
            n_err++;
            $display("FAIL reset_idle: got busy=%b gr=%b mute=%b req 0 0 1", busy, gen_reset, mute);
        end
    endtask

    task automatic test_crash_single();
        int gr_cnt, pc, guard, exp_len;
        exp_len = 12000000 >> SHIFT;
        req = 4'b1000; tick();
        n_cmp++;
        if (ack !== 4'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL crash_k: got ack=%b busy=%b req 0000 0", ack, busy);
        end
        tick();
        n_cmp++;
        if (ack !== 4'b1000 || mute !== 1'b1) begin
            n_err++;
            $display("FAIL crash_ack: got ack=%b mute=%b req 1000 1", ack, mute);
        end
        req = 0; tick();
        n_cmp++;
        if (cfg_amp !== 16'hFFFF || cfg_cutoff !== 3'd0 || gen_reset !== 1'b1 || active_id !== 2'd3) begin
            n_err++;
            $display("FAIL crash_cfg: got amp=%h cut=%0d gr=%b id=%0d req ffff 0 1 3",
                     cfg_amp, cfg_cutoff, gen_reset, active_id);
        end
        gr_cnt = 0; guard = 0;
        while (gen_reset === 1'b1 && guard < 20) begin gr_cnt++; guard++; tick(); end
        n_cmp++;
        if (gr_cnt != TRIG_CYC) begin
            n_err++;
            $display("FAIL crash_trig_len: got %0d req %0d", gr_cnt, TRIG_CYC);
        end
        pc = 0; guard = 0;
        while (mute === 1'b0 && guard < 100) begin pc++; guard++; tick(); end
        n_cmp++;
        if (pc != exp_len) begin
            n_err++;
            $display("FAIL crash_play_len: got %0d req %0d", pc, exp_len);
        end
        n_cmp++;
        if (busy !== 1'b0 || mute !== 1'b1) begin
            n_err++;
            $display("FAIL crash_end_idle: got busy=%b mute=%b req 0 1", busy, mute);
        end
    endtask

    task automatic test_sustain_thrust();
        req = 4'b0001; tick();
        n_cmp++;
        if (ack !== 4'b0001) begin
            n_err++;
            $display("FAIL thrust_ack: got %b req 0001", ack);
        end
        repeat (99) tick();
        n_cmp++;
        if (mute !== 1'b0 || cfg_cutoff !== 3'd3 || active_id !== 2'd0) begin
            n_err++;
            $display("FAIL thrust_play: got mute=%b cut=%0d id=%0d req 0 3 0", mute, cfg_cutoff, active_id);
        end
        req = 0; tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL thrust_release: got busy=%b req 0", busy);
        end
    endtask

    task automatic test_preempt();
        int guard;
        req = 4'b0001;
        repeat (10) tick();
        req = 4'b1001; tick(); tick();
        n_cmp++;
        if (ack !== 4'b1000) begin
            n_err++;
            $display("FAIL preempt_ack: got %b req 1000", ack);
        end
        req = 4'b0001; tick();
        n_cmp++;
        if (active_id !== 2'd3 || gen_reset !== 1'b1) begin
            n_err++;
            $display("FAIL preempt_trig: got id=%0d gr=%b req 3 1", active_id, gen_reset);
        end
        guard = 0;
        while (ack !== 4'b0001 && guard < 60) begin guard++; tick(); end
        n_cmp++;
        if (ack !== 4'b0001) begin
            n_err++;
            $display("FAIL preempt_reload: got ack=%b req 0001", ack);
        end
        tick();
        n_cmp++;
        if (active_id !== 2'd0 || cfg_cutoff !== 3'd3) begin
            n_err++;
            $display("FAIL preempt_thrust_back: got id=%0d cut=%0d req 0 3", active_id, cfg_cutoff);
        end
        req = 0;
        guard = 0;
        while (busy !== 1'b0 && guard < 20) begin guard++; tick(); end
    endtask

    task automatic test_no_interrupt();
        int guard, cnt, pc, bad_id;
        req = 4'b1000; tick(); req = 0;
        guard = 0;
        while (mute !== 1'b0 && guard < 20) begin guard++; tick(); end
        repeat (3) tick();
        req = 4'b0010; tick(); req = 0;
        cnt = 0; guard = 0; bad_id = 0;
        tick();
        while (ack === 4'b0 && guard < 40) begin
            if (mute === 1'b0) cnt++;
            if (active_id !== 2'd3) bad_id++;
            guard++; tick();
        end
        n_cmp++;
        if (ack !== 4'b0010 || cnt != (12000000 >> SHIFT) - 5 || bad_id != 0) begin
            n_err++;
            $display("FAIL no_interrupt: got ack=%b rest=%0d badid=%0d req 0010 %0d 0",
                     ack, cnt, bad_id, (12000000 >> SHIFT) - 5);
        end
        tick();
        n_cmp++;
        if (active_id !== 2'd1 || cfg_amp !== 16'h8000) begin
            n_err++;
            $display("FAIL landing_cfg: got id=%0d amp=%h req 1 8000", active_id, cfg_amp);
        end
        guard = 0;
        while (gen_reset === 1'b1 && guard < 20) begin guard++; tick(); end
        pc = 0; guard = 0;
        while (mute === 1'b0 && guard < 50) begin pc++; guard++; tick(); end
        n_cmp++;
        if (pc != (2000000 >> SHIFT)) begin
            n_err++;
            $display("FAIL landing_len: got %0d req %0d", pc, 2000000 >> SHIFT);
        end
    endtask

    task automatic test_retrigger();
        int guard, gr_cnt, pc;
        req = 4'b1000; tick(); req = 0;
        guard = 0;
        while (mute !== 1'b0 && guard < 20) begin guard++; tick(); end
        repeat (4) tick();
        req = 4'b1000; tick(); req = 0; tick();
        n_cmp++;
        if (ack !== 4'b1000 || mute !== 1'b1) begin
            n_err++;
            $display("FAIL retrig_ack: got ack=%b mute=%b req 1000 1", ack, mute);
        end
        tick();
        gr_cnt = 0; guard = 0;
        while (gen_reset === 1'b1 && guard < 20) begin gr_cnt++; guard++; tick(); end
        pc = 0; guard = 0;
        while (mute === 1'b0 && guard < 100) begin pc++; guard++; tick(); end
        n_cmp++;
        if (gr_cnt != TRIG_CYC || pc != (12000000 >> SHIFT)) begin
            n_err++;
            $display("FAIL retrig_len: got trig=%0d play=%0d req %0d %0d",
                     gr_cnt, pc, TRIG_CYC, 12000000 >> SHIFT);
        end
    endtask

    task automatic test_reset_mid_trig();
        int busy_cnt;
        req = 4'b1000; tick(); req = 0; tick(); tick();
        n_cmp++;
        if (gen_reset !== 1'b1) begin
            n_err++;
            $display("FAIL mid_trig_setup: got gr=%b req 1", gen_reset);
        end
        req = 4'b0010; tick();
        req = 0; reset = 1; tick();
        n_cmp++;
        if ({gen_reset, mute, busy, ack, active_id, cfg_amp, cfg_cutoff} !==
            {1'b1, 1'b1, 1'b0, 4'b0, 2'b0, 16'h0, 3'b0}) begin
            n_err++;
            $display("FAIL mid_trig_reset: got gr=%b mute=%b busy=%b ack=%b id=%0d amp=%h",
                     gen_reset, mute, busy, ack, active_id, cfg_amp);
        end
        reset = 0;
        busy_cnt = 0;
        repeat (30) begin tick(); if (busy !== 1'b0) busy_cnt++; end
        n_cmp++;
        if (busy_cnt != 0) begin
            n_err++;
            $display("FAIL mid_trig_no_replay: got %0d busy cycles req 0", busy_cnt);
        end
    endtask

    task automatic test_random();
        logic [38:0] got, exp;
        reset = 1; req = 0; tick(); reset = 0;
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 29) == 0) req[0] = ~req[0];
            for (int i = 1; i < 4; i++) begin
                if (req[i]) begin
                    if ($urandom_range(0, 3) == 0) req[i] = 1'b0;
                end else if ($urandom_range(0, 79) == 0) begin
                    req[i] = 1'b1;
                end
            end
            reset = ($urandom_range(0, 599) == 0);
            tick();
            got = {busy, mute, gen_reset, ack, active_id, cfg_cutoff, cfg_gain,
                   cfg_attack, cfg_decay, cfg_amp};
            exp = {m_ph != 0, m_ph != 3, e_gr, e_ack, 2'(m_own), e_cut, e_gain,
                   e_att, e_dec, e_amp};
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL random cyc %0d: got %h req %h (req=%b)", n, got, exp, req);
            end
        end
        reset = 0; req = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_crash_single();
        test_sustain_thrust();
        test_preempt();
        test_no_interrupt();
        test_retrigger();
        test_reset_mid_trig();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
